wb_commit: RTL and testbench
============================

// Module: wb_commit
// PURPOSE
//  Writeback side of the register file. Takes results from execute over valid/ready,
//  queues them in a DEPTH-entry FIFO, drains one per cycle onto the register-file write
//  port (in_enable/sel_in/in_reg/flags_in). Keeps a flags shadow so flags_in stays valid
//  on every write, and forwards queued values to decode. r15 results become PC redirects.
// PARAMETERS
//  DEPTH  4  FIFO entries (power of two, >=2)
//  DW     32 data width
// PORTS
//  clock          in   1   system clock, all state updates on posedge
//  reset          in   1   asynchronous, active-high; clears all state
//  res_valid      in   1   execute result valid
//  res_ready      out  1   unit can accept (= !full)
//  res_dest       in   4   destination register r0-r15
//  res_value      in   DW  result data
//  res_wr         in   1   result writes res_dest
//  res_setf       in   1   result updates flags
//  res_flags      in   4   new NZCV
//  hold           in   1   freeze draining (FIFO still accepts while not full)
//  in_enable      out  1   to regfile: write strobe
//  sel_in         out  4   to regfile: write select
//  in_reg         out  DW  to regfile: write data
//  flags_in       out  4   to regfile: flags data
//  pc_redir_valid out  1   one-cycle pulse: r15 result committed
//  pc_redir_addr  out  DW  redirect target
//  fwd_sel0/1     in   4   decode lookup selects
//  fwd_hit0/1     out  1   a queued write to that register is pending
//  fwd_val0/1     out  DW  youngest pending value for that register
//  busy           out  1   FIFO non-empty
// BEHAVIOUR
//  - Reset: FIFO empty, flags shadow = 4'b0, in_enable=0, pc_redir_valid=0, busy=0,
//    fwd_hit*=0, res_ready=1; sel_in/in_reg/flags_in/pc_redir_addr = 0. Reset mid-drain
//    discards all queued entries; no write strobe is issued after reset rises.
//  - Accept on posedge when res_valid && res_ready. Entry with res_wr=0 && res_setf=0
//    is consumed and dropped (not queued). Full FIFO: res_ready=0, no bypass.
//  - Write-port outputs are combinational from FIFO head; head pops on the posedge where
//    the regfile samples it. Latency: accepted at edge N -> written in regfile at edge N+1.
//  - Drain condition: !empty && !hold. Head with res_dest!=15: in_enable=1, sel_in=dest,
//    in_reg=value, flags_in = setf ? head flags : shadow; shadow <= flags_in on pop.
//  - Flags-only op (wr=0, setf=1): written as a normal write; producer supplies
//    res_value = current architectural value of res_dest (pass-through operand).
//  - Head with dest=15 && wr: in_enable=0 (PC owned by pc_in); pc_redir_valid=1,
//    pc_redir_addr=value for exactly that cycle, then pop. setf on an r15 entry is ignored.
//  - in_enable=0 whenever empty or hold. Simultaneous push+pop: count unchanged,
//    pointers wrap mod DEPTH.
//  - Forwarding: combinational over valid entries with wr=1, dest!=15; youngest match
//    wins; fwd_sel=15 never hits. Entry popping this cycle still counts as a hit.
// STRUCTURE
//  - Shared pkg: REG_PC=4'd15, FLAG_N/Z/C/V bit indices, entry field widths.
//  - One sub-module: wb_fifo (DEPTH x {dest,value,wr,setf,flags}, head/tail/count,
//    exposes all entries + valid mask for the forwarding compare).
//  - Top: accept filter, drain/write-port mux, flags shadow, redirect pulse, fwd priority.
// TESTING
//  1. Reset, push {r3,0xDEAD_BEEF,wr,setf=0} -> next edge in_enable=1,sel_in=3, flags_in=0.
//  2. Push 4 entries with hold=1 -> res_ready=0 after 4th; release hold -> 4 writes
//     in order, one per cycle, res_ready=1 after first pop.
//  3. Queue r5=0x11 then r5=0x22 under hold; fwd_sel0=5 -> hit0=1, val0=0x22; fwd_sel1=6 -> hit1=0.
//  4. Push {r2,setf,flags=4'b1010} then {r4,setf=0} -> flags_in 1010 on both writes.
//  5. Push {r15,0x0000_0100,wr} -> in_enable=0, pc_redir_valid=1 one cycle, addr=0x100.
//  6. Assert reset with 3 queued entries -> busy=0, in_enable=0 immediately; no writes.

Source files
------------

// File: rtl/wb_commit_pkg.sv
// Shared definitions for the writeback commit unit: register/flag constants
// and the queued-entry metadata layout.
package wb_commit_pkg;

  localparam int DEST_W  = 4;
  localparam int FLAGS_W = 4;

  localparam logic [DEST_W-1:0] REG_PC = 4'd15;

  // NZCV bit positions inside a flags word.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [DEST_W-1:0]  dest;
    logic               wr;
    logic               setf;
    logic [FLAGS_W-1:0] flags;
  } meta_t;

  // A queued entry that will land in a general register (forwardable).
  function automatic logic is_reg_write(input meta_t m);
    return m.wr && (m.dest != REG_PC);
  endfunction

  // A queued entry that retargets the PC instead of writing the regfile.
  function automatic logic is_redirect(input meta_t m);
    return m.wr && (m.dest == REG_PC);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry result queue. Exposes the head plus every slot and a valid mask
// so the parent can run its forwarding compare over all pending entries.
module wb_fifo
  import wb_commit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  meta_t            push_meta_i,
  input  logic [DW-1:0]    push_value_i,
  output meta_t            head_meta_o,
  output logic [DW-1:0]    head_value_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PW-1:0]    head_ptr_o,
  output logic [DEPTH-1:0] valid_o,
  output meta_t            meta_o  [DEPTH],
  output logic [DW-1:0]    value_o [DEPTH]
);

  meta_t         meta_q  [DEPTH];
  logic [DW-1:0] value_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  logic do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push) tail_d = tail_q + 1'b1;
    if (do_pop)  head_d = head_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the valid mask and count gate every read, so stale slots are never observed.
  always_ff @(posedge clock) begin
    if (do_push) begin
      meta_q[tail_q]  <= push_meta_i;
      value_q[tail_q] <= push_value_i;
    end
  end

  // A slot is live when its distance from head is below the occupancy.
  always_comb begin
    valid_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_o[i] = ({1'b0, PW'(i) - head_q} < count_q);
    end
  end

  assign head_meta_o  = meta_q[head_q];
  assign head_value_o = value_q[head_q];
  assign head_ptr_o   = head_q;
  assign meta_o       = meta_q;
  assign value_o      = value_q;

endmodule

// File: rtl/wb_commit.sv
// Writeback commit: filters execute results into a queue, drains one per cycle to
// the regfile write port, maintains the flags shadow, emits PC redirects, forwards.
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic [DEST_W-1:0]  res_dest,
  input  logic [DW-1:0]      res_value,
  input  logic               res_wr,
  input  logic               res_setf,
  input  logic [FLAGS_W-1:0] res_flags,
  input  logic               hold,
  output logic               in_enable,
  output logic [DEST_W-1:0]  sel_in,
  output logic [DW-1:0]      in_reg,
  output logic [FLAGS_W-1:0] flags_in,
  output logic               pc_redir_valid,
  output logic [DW-1:0]      pc_redir_addr,
  input  logic [DEST_W-1:0]  fwd_sel0,
  output logic               fwd_hit0,
  output logic [DW-1:0]      fwd_val0,
  input  logic [DEST_W-1:0]  fwd_sel1,
  output logic               fwd_hit1,
  output logic [DW-1:0]      fwd_val1,
  output logic               busy
);

  localparam int PW = $clog2(DEPTH);

  meta_t            push_meta, head_meta;
  logic [DW-1:0]    head_value;
  logic             push, pop, full, empty;
  logic [PW-1:0]    head_ptr;
  logic [DEPTH-1:0] valid;
  meta_t            ent_meta  [DEPTH];
  logic [DW-1:0]    ent_value [DEPTH];

  logic [FLAGS_W-1:0] shadow_q;

  // Results that neither write nor set flags are consumed here and never queued.
  assign res_ready = !full;
  assign push      = res_valid && res_ready && (res_wr || res_setf);
  assign pop       = !empty && !hold;
  assign busy      = !empty;

  assign push_meta = '{dest: res_dest, wr: res_wr, setf: res_setf, flags: res_flags};

  wb_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push_i       (push),
    .pop_i        (pop),
    .push_meta_i  (push_meta),
    .push_value_i (res_value),
    .head_meta_o  (head_meta),
    .head_value_o (head_value),
    .full_o       (full),
    .empty_o      (empty),
    .head_ptr_o   (head_ptr),
    .valid_o      (valid),
    .meta_o       (ent_meta),
    .value_o      (ent_value)
  );

  // r15 never strobes the regfile; its flags are ignored and the shadow is kept.
  always_comb begin
    in_enable      = pop && (head_meta.dest != REG_PC);
    pc_redir_valid = pop && is_redirect(head_meta);
    sel_in         = '0;
    in_reg         = '0;
    flags_in       = shadow_q;
    pc_redir_addr  = '0;
    if (in_enable) begin
      sel_in = head_meta.dest;
      in_reg = head_value;
      if (head_meta.setf) flags_in = head_meta.flags;
    end
    if (pc_redir_valid) pc_redir_addr = head_value;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)          shadow_q <= '0;
    else if (in_enable) shadow_q <= flags_in;
  end

  // Walk oldest to youngest so the last match (youngest) wins.
  logic [PW-1:0] idx;
  always_comb begin
    fwd_hit0 = 1'b0;
    fwd_val0 = '0;
    fwd_hit1 = 1'b0;
    fwd_val1 = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_ptr + PW'(k);
      if (valid[idx] && is_reg_write(ent_meta[idx])) begin
        if (ent_meta[idx].dest == fwd_sel0) begin
          fwd_hit0 = 1'b1;
          fwd_val0 = ent_value[idx];
        end
        if (ent_meta[idx].dest == fwd_sel1) begin
          fwd_hit1 = 1'b1;
          fwd_val1 = ent_value[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: a scoreboard of expected commits fed by the
// driver, a table of result vectors, and directed multi-cycle sequences.
module tb_wb_commit;
  import wb_commit_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clock, reset;
  logic          res_valid, res_ready, res_wr, res_setf, hold;
  logic [3:0]    res_dest, res_flags;
  logic [DW-1:0] res_value;
  logic          in_enable, pc_redir_valid, busy;
  logic [3:0]    sel_in, flags_in;
  logic [DW-1:0] in_reg, pc_redir_addr;
  logic [3:0]    fwd_sel0, fwd_sel1;
  logic          fwd_hit0, fwd_hit1;
  logic [DW-1:0] fwd_val0, fwd_val1;

  wb_commit #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clock          (clock),
    .reset          (reset),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_dest       (res_dest),
    .res_value      (res_value),
    .res_wr         (res_wr),
    .res_setf       (res_setf),
    .res_flags      (res_flags),
    .hold           (hold),
    .in_enable      (in_enable),
    .sel_in         (sel_in),
    .in_reg         (in_reg),
    .flags_in       (flags_in),
    .pc_redir_valid (pc_redir_valid),
    .pc_redir_addr  (pc_redir_addr),
    .fwd_sel0       (fwd_sel0),
    .fwd_hit0       (fwd_hit0),
    .fwd_val0       (fwd_val0),
    .fwd_sel1       (fwd_sel1),
    .fwd_hit1       (fwd_hit1),
    .fwd_val1       (fwd_val1),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef enum logic [1:0] {EXP_NONE, EXP_WRITE, EXP_REDIR} exp_kind_e;

  typedef struct {
    logic [3:0]  dest;
    logic [31:0] value;
    logic        wr;
    logic        setf;
    logic [3:0]  flags;
    exp_kind_e   kind;
    logic [3:0]  exp_flags;
  } vec_t;

  typedef struct {
    exp_kind_e   kind;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [3:0]  flags;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Commit monitor: samples late in the low phase, after inputs have settled.
  always begin
    exp_t e;
    @(negedge clock);
    #3;
    if (!reset && (in_enable || pc_redir_valid)) begin
      if (sb.size() == 0) begin
        check("unexpected_commit", {30'b0, pc_redir_valid, in_enable}, 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.kind == EXP_REDIR) begin
          check("redir_valid", pc_redir_valid, 1);
          check("redir_no_we", in_enable, 0);
          check("redir_addr", pc_redir_addr, e.data);
        end else begin
          check("wr_enable", in_enable, 1);
          check("wr_sel", sel_in, e.sel);
          check("wr_data", in_reg, e.data);
          check("wr_flags", flags_in, e.flags);
          check("wr_no_redir", pc_redir_valid, 0);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the sampling posedge.
  task automatic drive(input logic [3:0] d, input logic [31:0] v, input logic w, input logic s,
                       input logic [3:0] f, input exp_kind_e k, input logic [3:0] ef);
    logic acc;
    res_valid = 1'b1;
    res_dest  = d;
    res_value = v;
    res_wr    = w;
    res_setf  = s;
    res_flags = f;
    #1;
    acc = res_ready;
    @(posedge clock);
    if (acc && k != EXP_NONE) sb.push_back('{k, d, v, ef});
    @(negedge clock);
    res_valid = 1'b0;
  endtask

  // Waits (bounded) for every expected commit, then confirms the unit went idle.
  task automatic wait_drain(input string name);
    int i;
    i = 0;
    @(negedge clock);
    while (sb.size() != 0 && i < 40) begin
      @(negedge clock);
      i++;
    end
    check({name, "_drained"}, sb.size(), 0);
    #1;
    check({name, "_idle"}, busy, 0);
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'd2,  32'h0000_2222, 1'b1, 1'b1, 4'b1010, EXP_WRITE, 4'b1010};
    vecs[1] = '{4'd4,  32'h0000_4444, 1'b1, 1'b0, 4'b0000, EXP_WRITE, 4'b1010};
    vecs[2] = '{4'd7,  32'h0000_0007, 1'b0, 1'b0, 4'b1111, EXP_NONE,  4'b0000};
    vecs[3] = '{4'd15, 32'h0000_0100, 1'b1, 1'b1, 4'b1111, EXP_REDIR, 4'b0000};
    vecs[4] = '{4'd9,  32'h0000_0099, 1'b0, 1'b1, 4'b0101, EXP_WRITE, 4'b0101};
    vecs[5] = '{4'd1,  32'h0000_0011, 1'b1, 1'b0, 4'b0000, EXP_WRITE, 4'b0101};
    vecs[6] = '{4'd0,  32'hFFFF_FFFF, 1'b1, 1'b1, 4'b0011, EXP_WRITE, 4'b0011};
    vecs[7] = '{4'd14, 32'h0000_0000, 1'b1, 1'b0, 4'b0000, EXP_WRITE, 4'b0011};

    reset = 1'b1; res_valid = 1'b0; res_dest = '0; res_value = '0;
    res_wr = 1'b0; res_setf = 1'b0; res_flags = '0; hold = 1'b0;
    fwd_sel0 = 4'd0; fwd_sel1 = 4'd0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_ready", res_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_we", in_enable, 0);
    check("rst_redir", pc_redir_valid, 0);
    check("rst_hit0", fwd_hit0, 0);
    check("rst_sel", sel_in, 0);
    check("rst_data", in_reg, 0);
    check("rst_flags", flags_in, 0);
    check("rst_addr", pc_redir_addr, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Single write: accepted at one edge, presented before the next.
    drive(4'd3, 32'hDEAD_BEEF, 1'b1, 1'b0, 4'b0000, EXP_WRITE, 4'b0000);
    #1;
    check("t1_we", in_enable, 1);
    check("t1_sel", sel_in, 3);
    check("t1_flags", flags_in, 0);
    check("t1_busy", busy, 1);
    wait_drain("t1");

    // Fill under hold, reject while full, then drain in order.
    hold = 1'b1;
    for (int i = 0; i < 4; i++)
      drive(4'(10 + i), 32'hA0 + i, 1'b1, 1'b0, 4'b0000, EXP_WRITE, 4'b0000);
    #1;
    check("t2_full_ready", res_ready, 0);
    check("t2_hold_we", in_enable, 0);
    check("t2_busy", busy, 1);
    @(negedge clock);
    drive(4'd8, 32'h88, 1'b1, 1'b0, 4'b0000, EXP_WRITE, 4'b0000);
    hold = 1'b0;
    #1;
    check("t2_release_we", in_enable, 1);
    check("t2_release_sel", sel_in, 10);
    @(negedge clock);
    #1;
    check("t2_ready_after_pop", res_ready, 1);
    wait_drain("t2");

    // Forwarding: youngest match wins, r15 and absent registers never hit.
    hold = 1'b1;
    drive(4'd5,  32'h11,  1'b1, 1'b0, 4'b0000, EXP_WRITE, 4'b0000);
    drive(4'd15, 32'h200, 1'b1, 1'b0, 4'b0000, EXP_REDIR, 4'b0000);
    drive(4'd5,  32'h22,  1'b1, 1'b0, 4'b0000, EXP_WRITE, 4'b0000);
    fwd_sel0 = 4'd5;
    fwd_sel1 = 4'd6;
    #1;
    check("t3_hit0", fwd_hit0, 1);
    check("t3_val0", fwd_val0, 32'h22);
    check("t3_hit1_r6", fwd_hit1, 0);
    fwd_sel1 = 4'd15;
    #1;
    check("t3_hit1_r15", fwd_hit1, 0);
    fwd_sel1 = 4'd5;
    #1;
    check("t3_hit1_r5", fwd_hit1, 1);
    check("t3_val1_r5", fwd_val1, 32'h22);
    @(negedge clock);
    hold = 1'b0;
    @(negedge clock);
    #1;
    check("t3_hit_after_pop", fwd_hit0, 1);
    check("t3_val_after_pop", fwd_val0, 32'h22);
    wait_drain("t3");
    #1;
    check("t3_hit_empty", fwd_hit0, 0);
    @(negedge clock);

    // Back-to-back table: flags shadow, dropped ops, flags-only op, r15 redirect.
    for (int i = 0; i < 8; i++)
      drive(vecs[i].dest, vecs[i].value, vecs[i].wr, vecs[i].setf, vecs[i].flags,
            vecs[i].kind, vecs[i].exp_flags);
    wait_drain("tbl");

    // Redirect is a single-cycle pulse with no regfile strobe.
    drive(4'd15, 32'h0000_0100, 1'b1, 1'b0, 4'b0000, EXP_REDIR, 4'b0000);
    #1;
    check("t5_redir", pc_redir_valid, 1);
    check("t5_no_we", in_enable, 0);
    check("t5_addr", pc_redir_addr, 32'h100);
    @(negedge clock);
    #1;
    check("t5_redir_drop", pc_redir_valid, 0);
    check("t5_addr_clear", pc_redir_addr, 0);
    check("t5_flags_kept", flags_in, 4'b0011);
    wait_drain("t5");

    // Reset with queued entries discards them and silences the write port.
    fwd_sel0 = 4'd1;
    hold = 1'b1;
    for (int i = 0; i < 3; i++)
      drive(4'(1 + i), 32'h300 + i, 1'b1, 1'b0, 4'b0000, EXP_WRITE, 4'b0011);
    #1;
    check("t6_busy_before", busy, 1);
    check("t6_hit_before", fwd_hit0, 1);
    reset = 1'b1;
    #1;
    sb.delete();
    check("t6_busy", busy, 0);
    check("t6_we", in_enable, 0);
    check("t6_ready", res_ready, 1);
    check("t6_hit", fwd_hit0, 0);
    check("t6_flags", flags_in, 0);
    @(negedge clock);
    reset = 1'b0;
    hold = 1'b0;
    repeat (6) @(negedge clock);
    #1;
    check("t6_still_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
